// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive blocks: FSM state
// encoding, line levels and a frame-length helper.
package uart_pkg;

   // Serialiser FSM state encoding
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   // Line levels
   localparam logic UART_IDLE_LEVEL = 1'b1;
   localparam logic START_LEVEL     = 1'b0;

   // Standard 8N1 frame length in bit periods
   localparam int FRAME_LEN_8N1 = 10;

   // Bit periods occupied by one frame on the line
   function automatic int frame_len(input int data_bits, input int parity_en,
                                    input int stop_bits);
      return 32'sd1 + data_bits + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous FIFO with registered level, not-full and empty flags.
// Pushes while full and pops while empty are ignored. Usable on either the
// transmit or receive side of the UART.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_push_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_pop_data,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_not_full,
   output logic                   o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [LVL_W-1:0] w_level_next;
   logic             r_not_full;
   logic             r_empty;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push  = i_push & r_not_full;
   assign w_do_pop   = i_pop & ~r_empty;
   assign o_pop_data = r_mem[r_rd_ptr];
   assign o_level    = r_level;
   assign o_not_full = r_not_full;
   assign o_empty    = r_empty;

   // Next occupancy: a simultaneous push and pop leaves the level unchanged
   always_comb begin
      w_level_next = r_level;
      if (w_do_push && !w_do_pop) begin
         w_level_next = r_level + LVL_W'(1);
      end else if (!w_do_push && w_do_pop) begin
         w_level_next = r_level - LVL_W'(1);
      end else begin
         w_level_next = r_level;
      end
   end

   // Pointers, level and flags; flags are derived from the next level so they are flops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_not_full <= 1'b1;
         r_empty    <= 1'b1;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_level    <= w_level_next;
         r_not_full <= (w_level_next != LVL_FULL);
         r_empty    <= (w_level_next == LVL_W'(0));
      end
   end

   // Storage array; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: queues producer bytes in a FIFO and serialises them
// LSB-first as start / data / optional parity / stop bits, one bit per
// uart_clock cycle. A new frame only starts while cts_n is low; frames
// already on the line always complete. tx comes straight from a flop.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                        uart_clock,
   input  logic                        reset,
   input  logic [DATA_BITS-1:0]        wr_data,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic                        cts_n,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow
);

   localparam int         LVL_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic       PAR_INIT  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

   logic [2:0]           r_state;
   logic [2:0]           w_state_next;
   logic                 r_tx;
   logic                 w_tx_next;
   logic                 r_busy;
   logic                 w_busy_next;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_next;
   logic [2:0]           r_bit_cnt;
   logic [2:0]           w_bit_cnt_next;
   logic                 r_par;
   logic                 w_par_next;
   logic                 r_overflow;

   logic                 w_fifo_ready;
   logic                 w_fifo_empty;
   logic [DATA_BITS-1:0] w_fifo_data;
   logic [LVL_W-1:0]     w_fifo_level;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_can_start;
   logic                 w_data_last;
   logic                 w_stop_last;

   assign w_push      = wr_valid & w_fifo_ready;
   assign w_can_start = ~w_fifo_empty & ~cts_n;
   assign w_data_last = (r_bit_cnt == LAST_DATA);
   assign w_stop_last = (r_bit_cnt == LAST_STOP);
   assign w_pop       = w_can_start &
                        ((r_state == IDLE) | ((r_state == STOP) & w_stop_last));

   assign wr_ready   = w_fifo_ready;
   assign tx         = r_tx;
   assign busy       = r_busy;
   assign fifo_level = w_fifo_level;
   assign overflow   = r_overflow;

   uart_byte_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (uart_clock),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (wr_data),
      .i_pop       (w_pop),
      .o_pop_data  (w_fifo_data),
      .o_level     (w_fifo_level),
      .o_not_full  (w_fifo_ready),
      .o_empty     (w_fifo_empty)
   );

   // FSM state register
   always_ff @(posedge uart_clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; back-to-back frames go STOP -> START with no idle cycle
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_pop) w_state_next = START;
            else       w_state_next = IDLE;
         end
         START: begin
            w_state_next = DATA;
         end
         DATA: begin
            if (!w_data_last)        w_state_next = DATA;
            else if (PARITY_EN != 0) w_state_next = PARITY;
            else                     w_state_next = STOP;
         end
         PARITY: begin
            w_state_next = STOP;
         end
         STOP: begin
            if (!w_stop_last) w_state_next = STOP;
            else if (w_pop)   w_state_next = START;
            else              w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Output/datapath next values: line bit, shifter, bit counter, parity, busy
   always_comb begin
      w_tx_next      = r_tx;
      w_busy_next    = r_busy;
      w_shift_next   = r_shift;
      w_bit_cnt_next = r_bit_cnt;
      w_par_next     = r_par;
      case (r_state)
         IDLE: begin
            if (w_pop) begin
               w_shift_next   = w_fifo_data;
               w_bit_cnt_next = 3'd0;
               w_par_next     = PAR_INIT;
               w_tx_next      = START_LEVEL;
               w_busy_next    = 1'b1;
            end else begin
               w_tx_next   = UART_IDLE_LEVEL;
               w_busy_next = 1'b0;
            end
         end
         START: begin
            w_tx_next    = r_shift[0];
            w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
         end
         DATA: begin
            // r_tx is the data bit currently on the line
            w_par_next = r_par ^ r_tx;
            if (w_data_last) begin
               w_bit_cnt_next = 3'd0;
               if (PARITY_EN != 0) w_tx_next = r_par ^ r_tx;
               else                w_tx_next = UART_IDLE_LEVEL;
            end else begin
               w_bit_cnt_next = r_bit_cnt + 3'd1;
               w_tx_next      = r_shift[0];
               w_shift_next   = {1'b0, r_shift[DATA_BITS-1:1]};
            end
         end
         PARITY: begin
            w_tx_next      = UART_IDLE_LEVEL;
            w_bit_cnt_next = 3'd0;
         end
         STOP: begin
            if (!w_stop_last) begin
               w_bit_cnt_next = r_bit_cnt + 3'd1;
            end else if (w_pop) begin
               w_shift_next   = w_fifo_data;
               w_bit_cnt_next = 3'd0;
               w_par_next     = PAR_INIT;
               w_tx_next      = START_LEVEL;
               w_busy_next    = 1'b1;
            end else begin
               w_tx_next   = UART_IDLE_LEVEL;
               w_busy_next = 1'b0;
            end
         end
         default: begin
            w_tx_next   = UART_IDLE_LEVEL;
            w_busy_next = 1'b0;
         end
      endcase
   end

   // Datapath registers; tx is reset high so the line idles immediately on reset
   always_ff @(posedge uart_clock or posedge reset) begin
      if (reset) begin
         r_tx      <= UART_IDLE_LEVEL;
         r_busy    <= 1'b0;
         r_shift   <= '0;
         r_bit_cnt <= 3'd0;
         r_par     <= 1'b0;
      end else begin
         r_tx      <= w_tx_next;
         r_busy    <= w_busy_next;
         r_shift   <= w_shift_next;
         r_bit_cnt <= w_bit_cnt_next;
         r_par     <= w_par_next;
      end
   end

   // Sticky overflow: a write offered while the FIFO is full
   always_ff @(posedge uart_clock or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (wr_valid && !w_fifo_ready) begin
         r_overflow <= 1'b1;
      end else begin
         r_overflow <= r_overflow;
      end
   end

endmodule
